// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding instruction-bus fetcher with a
// one-slot presentation register toward IF/ID, delayed-branch redirect and flush.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        adel_o,
    output logic        stallreq_o
);

    // state | meaning
    // IDLE  | no bus access outstanding; may issue a fetch or present an address error
    // WAIT  | fetch outstanding, data will be presented
    // HOLD  | fetched word presented but IF/ID stalled; advance deferred
    // ABORT | flushed fetch still outstanding; data will be dropped
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] redirect_target;
    logic        redirect_pending;
    logic        aligned;
    logic        slot_blocked;
    logic        issue;
    logic        advance;
    logic [31:0] advance_pc;
    logic        bus_busy;
    logic        unused_stall;

    assign unused_stall = ^stall[5:2];

    assign aligned      = (fetch_pc[1:0] == 2'b00);
    // a presented slot that IF/ID has not taken yet must not be overwritten
    assign slot_blocked = inst_valid_o && stall[1];
    assign bus_busy     = (state == S_WAIT) || (state == S_ABORT);
    assign issue        = !rst && (state == S_IDLE) && !flush && !stall[0]
                          && aligned && !slot_blocked;

    assign ibus_req_o   = issue || bus_busy;
    assign ibus_addr_o  = issue ? fetch_pc : (bus_busy ? req_addr : 32'd0);
    assign stallreq_o   = (state == S_WAIT) && !ibus_ack_i;

    assign advance    = !flush && !stall[1] &&
                        (((state == S_WAIT) && ibus_ack_i) || (state == S_HOLD));
    assign advance_pc = redirect_pending ? redirect_target : fetch_pc + 32'd4;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (issue) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (ibus_ack_i)
                    state_next = (!flush && stall[1]) ? S_HOLD : S_IDLE;
                else if (flush)
                    state_next = S_ABORT;
            end
            S_HOLD: begin
                if (flush || !stall[1]) state_next = S_IDLE;
            end
            S_ABORT: begin
                if (ibus_ack_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            fetch_pc         <= RESET_PC;
            req_addr         <= 32'd0;
            redirect_pending <= 1'b0;
            redirect_target  <= 32'd0;
        end else begin
            state <= state_next;
            if (issue) req_addr <= fetch_pc;
            if (flush) begin
                fetch_pc         <= new_pc;
                redirect_pending <= 1'b0;
            end else begin
                if (advance) fetch_pc <= advance_pc;
                // a new branch overrides the clear from a redirect consumed this cycle
                if (branch_flag_i) begin
                    redirect_pending <= 1'b1;
                    redirect_target  <= branch_target_address_i;
                end else if (advance) begin
                    redirect_pending <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o         <= 32'd0;
            inst_o       <= 32'd0;
            inst_valid_o <= 1'b0;
            adel_o       <= 1'b0;
        end else if (flush) begin
            inst_valid_o <= 1'b0;
            adel_o       <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (ibus_ack_i) begin
                        inst_valid_o <= 1'b1;
                        pc_o         <= req_addr;
                        inst_o       <= ibus_rdata_i;
                        adel_o       <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall[1]) inst_valid_o <= 1'b0;
                end
                S_IDLE: begin
                    if (!slot_blocked) begin
                        if (!aligned) begin
                            inst_valid_o <= 1'b1;
                            pc_o         <= fetch_pc;
                            inst_o       <= 32'd0;
                            adel_o       <= 1'b1;
                        end else begin
                            inst_valid_o <= 1'b0;
                            adel_o       <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a transaction-level model of the fetcher.
module tb_if_fetch;

    localparam logic [31:0] RPC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        adel_o;
    logic        stallreq_o;

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
        .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_ack_i(ibus_ack_i),
        .ibus_rdata_i(ibus_rdata_i), .pc_o(pc_o), .inst_o(inst_o),
        .inst_valid_o(inst_valid_o), .adel_o(adel_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: next fetch address, pending redirect, outstanding bus access, presented slot
    logic [31:0] m_pc, m_tgt, m_out_addr, m_pco, m_inst;
    bit          m_redir, m_out, m_discard, m_valid, m_adel, m_defer;
    int          m_cnt, m_delay;

    task automatic model_reset();
        m_pc = RPC; m_tgt = 0; m_redir = 0;
        m_out = 0; m_out_addr = 0; m_discard = 0; m_cnt = 0; m_delay = 0;
        m_valid = 0; m_pco = 0; m_inst = 0; m_adel = 0; m_defer = 0;
    endtask

    task automatic model_advance();
        if (m_redir) m_pc = m_tgt;
        else         m_pc = m_pc + 32'd4;
        m_redir = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        int r = $urandom_range(15);
        if (r == 0) return 32'hFFFFFFFC;
        if (r == 1) return RPC + 32'($urandom_range(255)) * 4 + 32'd2;
        return RPC + 32'($urandom_range(1023)) * 4;
    endfunction

    task automatic drive(input bit quiet);
        stall[0]   = !quiet && ($urandom_range(3) == 0);
        stall[1]   = !quiet && ($urandom_range(3) == 0);
        stall[5:2] = quiet ? 4'd0 : 4'($urandom_range(15));
        flush      = !quiet && ($urandom_range(19) == 0);
        new_pc     = pick_addr();
        branch_flag_i           = !quiet && ($urandom_range(7) == 0);
        branch_target_address_i = pick_addr();
        ibus_rdata_i = $urandom;
        if (m_out) ibus_ack_i = (m_cnt >= m_delay);
        else       ibus_ack_i = !quiet && ($urandom_range(9) == 0);
    endtask

    task automatic check_outputs();
        bit          e_issue;
        logic [31:0] e_addr;
        e_issue = !m_out && !m_defer && !flush && !stall[0] && (m_pc[1:0] == 2'b00)
                  && !(m_valid && stall[1]);
        e_addr  = m_out ? m_out_addr : (e_issue ? m_pc : 32'd0);
        check("ibus_req", 32'(ibus_req_o), 32'(m_out || e_issue));
        check("ibus_addr", ibus_addr_o, e_addr);
        check("stallreq", 32'(stallreq_o), 32'(m_out && !m_discard && !ibus_ack_i));
        check("inst_valid", 32'(inst_valid_o), 32'(m_valid));
        if (m_valid) begin
            check("pc", pc_o, m_pco);
            check("inst", inst_o, m_inst);
            check("adel", 32'(adel_o), 32'(m_adel));
        end
    endtask

    task automatic model_step(input bit quiet);
        if (flush) begin
            if (m_out) begin
                if (ibus_ack_i) begin m_out = 0; m_discard = 0; end
                else begin m_discard = 1; m_cnt++; end
            end
            m_pc = new_pc; m_redir = 0; m_valid = 0; m_adel = 0; m_defer = 0;
        end else begin
            if (m_out) begin
                if (ibus_ack_i) begin
                    m_out = 0;
                    if (!m_discard) begin
                        m_valid = 1; m_pco = m_out_addr; m_inst = ibus_rdata_i; m_adel = 0;
                        if (stall[1]) m_defer = 1;
                        else          model_advance();
                    end
                    m_discard = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_defer) begin
                if (!stall[1]) begin m_valid = 0; m_defer = 0; model_advance(); end
            end else if (!(m_valid && stall[1])) begin
                if (m_pc[1:0] != 2'b00) begin
                    m_valid = 1; m_pco = m_pc; m_inst = 0; m_adel = 1;
                end else begin
                    m_valid = 0; m_adel = 0;
                    if (!stall[0]) begin
                        m_out = 1; m_out_addr = m_pc; m_cnt = 0;
                        m_delay = quiet ? 0 : $urandom_range(3);
                    end
                end
            end
            if (branch_flag_i) begin m_redir = 1; m_tgt = branch_target_address_i; end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, 32'(ibus_req_o), 32'd0);
        check({tag, "_addr"}, ibus_addr_o, 32'd0);
        check({tag, "_stallreq"}, 32'(stallreq_o), 32'd0);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_pc"}, pc_o, 32'd0);
        check({tag, "_inst"}, inst_o, 32'd0);
        check({tag, "_adel"}, 32'(adel_o), 32'd0);
    endtask

    task automatic run_cycles(input int n, input bit quiet);
        for (int i = 0; i < n; i++) begin
            drive(quiet);
            @(negedge clk);
            check_outputs();
            model_step(quiet);
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0);
        stall = 6'd0; flush = 1'b0; ibus_ack_i = 1'b1;
        #1;
        check_reset_values("rst_async");
        @(negedge clk);
        check_reset_values("rst_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        stall = 6'd0; flush = 1'b0; new_pc = 32'd0; branch_flag_i = 1'b0;
        branch_target_address_i = 32'd0; ibus_ack_i = 1'b1; ibus_rdata_i = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        run_cycles(8, 1'b1);
        run_cycles(1500, 1'b0);
        apply_reset();
        run_cycles(6, 1'b1);
        run_cycles(1500, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
